// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, encoder field classes and encoder FSM states.
// The opcode constants are also used by the main control decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] CLS_LOAD   = 3'd0;
    localparam logic [2:0] CLS_STORE  = 3'd1;
    localparam logic [2:0] CLS_RTYPE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_ITYPE  = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_JALR   = 3'd6;
    localparam logic [2:0] CLS_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2,
        ST_FULL = 2'd3
    } enc_state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I packer: turns a decoded field bundle into an instruction word
// and flags bundles that cannot be encoded (bad class, immediate out of range/misaligned).
module instr_field_packer
    import riscv_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        f7b5,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic signed [31:0] simm;
    logic               fits_i;
    logic               fits_b;
    logic               fits_j;
    logic               is_shift;

    assign simm     = imm;
    assign fits_i   = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign fits_b   = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
    assign fits_j   = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        word = '0;
        err  = 1'b0;
        case (cls)
            CLS_LOAD: begin
                word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                err  = !fits_i;
            end
            CLS_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                err  = !fits_i;
            end
            CLS_RTYPE: begin
                word = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
            end
            CLS_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                err  = !fits_b;
            end
            CLS_ITYPE: begin
                // Shifts reuse the upper immediate bits as a funct7 and take only a 5-bit shamt
                if (is_shift) begin
                    word = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OP_ITYPE};
                    err  = (imm[31:5] != 27'd0);
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
                    err  = !fits_i;
                end
            end
            CLS_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                err  = !fits_j;
            end
            CLS_JALR: begin
                word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                err  = !fits_i;
            end
            default: begin
                word = '0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: accepts a field bundle, encodes it over three cycles and
// writes the word to instruction memory at an auto-incrementing address.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              full
);

    enc_state_t  state, state_d;
    logic        accept;

    logic [2:0]  cls_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  f3_q;
    logic        f7b5_q;
    logic [31:0] imm_q;

    logic [31:0] pack_word, word_q;
    logic        pack_err, enc_err_q;

    assign full     = (state == ST_FULL);
    assign in_ready = (state == ST_IDLE) && !full && !start;
    assign accept   = in_valid && in_ready;

    instr_field_packer u_packer (
        .cls    (cls_q),
        .rd     (rd_q),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .funct3 (f3_q),
        .f7b5   (f7b5_q),
        .imm    (imm_q),
        .word   (pack_word),
        .err    (pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // start overrides every transition, aborting an encode before it reaches memory
    always_comb begin
        state_d = state;
        if (start) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_d = ST_ENC;
                ST_ENC:  state_d = ST_WR;
                ST_WR: begin
                    if (!enc_err_q && (mem_addr == '1)) state_d = ST_FULL;
                    else                                state_d = ST_IDLE;
                end
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            f3_q      <= '0;
            f7b5_q    <= 1'b0;
            imm_q     <= '0;
            word_q    <= '0;
            enc_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cls_q  <= in_class;
                rd_q   <= in_rd;
                rs1_q  <= in_rs1;
                rs2_q  <= in_rs2;
                f3_q   <= in_funct3;
                f7b5_q <= in_f7b5;
                imm_q  <= in_imm;
            end
            if (state == ST_ENC) begin
                word_q    <= pack_word;
                enc_err_q <= pack_err;
            end
        end
    end

    // Address and count advance the cycle after the strobe so they stay put during the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                mem_addr <= '0;
                count    <= '0;
                err      <= 1'b0;
            end else begin
                if (state == ST_WR) begin
                    if (enc_err_q) begin
                        err <= 1'b1;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_wdata <= word_q;
                    end
                end
                if (mem_we) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                    count    <= count + (ADDR_W + 1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder, built with a 4-entry memory so the
// full/wrap behaviour is reached after four writes.
module tb_instr_encoder;
    import riscv_pkg::*;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic              in_f7b5;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              err;
    logic              full;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_f7b5   (in_f7b5),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .err       (err),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns 1ns after the accepting posedge with in_valid dropped
    task automatic applyStimulus(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                                 input logic [31:0] imm);
        bit got = 0;
        in_class  = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_f7b5   = f7b5;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
                got = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            in_valid = 1'b0;
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic expectWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        checkOutput({tag, "_we_enc"}, 32'(mem_we), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_we_wr"}, 32'(mem_we), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_we"}, 32'(mem_we), 32'd1);
        checkOutput({tag, "_addr"}, 32'(mem_addr), addr);
        checkOutput({tag, "_data"}, mem_wdata, data);
    endtask

    task automatic expectReject(input string tag, input logic [31:0] addr, input logic [31:0] cnt);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput({tag, "_no_we"}, 32'(mem_we), 32'd0);
        end
        checkOutput({tag, "_err"}, 32'(err), 32'd1);
        checkOutput({tag, "_addr"}, 32'(mem_addr), addr);
        checkOutput({tag, "_count"}, 32'(count), cnt);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_f7b5 = 1'b0; in_imm = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);

        applyStimulus(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        expectWrite("addi", 32'd0, 32'h00500093);
        @(negedge clk);
        checkOutput("addi_we_drop", 32'(mem_we), 32'd0);
        checkOutput("addi_count", 32'(count), 32'd1);
        checkOutput("addi_addr_inc", 32'(mem_addr), 32'd1);

        applyStimulus(CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0);
        expectWrite("add", 32'd1, 32'h002081B3);
        applyStimulus(CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
        expectWrite("sub", 32'd2, 32'h402081B3);
        applyStimulus(CLS_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8);
        expectWrite("sw_last", 32'd3, 32'h0020A423);

        // memory now full: a held request must be refused
        in_class = CLS_ITYPE; in_rd = 5'd1; in_rs1 = 5'd0; in_funct3 = 3'b000; in_imm = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("full_no_we", 32'(mem_we), 32'd0);
            checkOutput("full_ready", 32'(in_ready), 32'd0);
            checkOutput("full_flag", 32'(full), 32'd1);
        end
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_addr_wrap", 32'(mem_addr), 32'd0);
        in_valid = 1'b0;
        pulseStart();
        checkOutput("start_full", 32'(full), 32'd0);
        checkOutput("start_count", 32'(count), 32'd0);
        checkOutput("start_ready", 32'(in_ready), 32'd1);
        checkOutput("start_addr", 32'(mem_addr), 32'd0);

        applyStimulus(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFFC);
        expectWrite("beq", 32'd0, 32'hFE208EE3);
        applyStimulus(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8);
        expectWrite("jal", 32'd1, 32'h008000EF);
        @(negedge clk);
        checkOutput("jal_count", 32'(count), 32'd2);

        applyStimulus(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3);
        expectReject("err_b_odd", 32'd2, 32'd2);
        applyStimulus(CLS_RSVD, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'd0);
        expectReject("err_class7", 32'd2, 32'd2);
        applyStimulus(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4096);
        expectReject("err_i_range", 32'd2, 32'd2);
        applyStimulus(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd4096);
        expectReject("err_b_range", 32'd2, 32'd2);
        applyStimulus(CLS_ITYPE, 5'd5, 5'd6, 5'd0, 3'b001, 1'b0, 32'd32);
        expectReject("err_shamt", 32'd2, 32'd2);

        applyStimulus(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        expectWrite("addi_after_err", 32'd2, 32'h00500093);
        @(negedge clk);
        checkOutput("err_sticky", 32'(err), 32'd1);
        checkOutput("err_count", 32'(count), 32'd3);
        pulseStart();
        checkOutput("start_err", 32'(err), 32'd0);
        checkOutput("start_count2", 32'(count), 32'd0);

        applyStimulus(CLS_ITYPE, 5'd5, 5'd6, 5'd0, 3'b101, 1'b1, 32'd3);
        expectWrite("srai", 32'd0, 32'h40335293);
        applyStimulus(CLS_LOAD, 5'd5, 5'd1, 5'd0, 3'b010, 1'b0, 32'hFFFF_FFFC);
        expectWrite("lw", 32'd1, 32'hFFC0A283);
        applyStimulus(CLS_JALR, 5'd1, 5'd5, 5'd0, 3'b111, 1'b0, 32'd0);
        expectWrite("jalr", 32'd2, 32'h000280E7);
        @(negedge clk);
        checkOutput("jalr_count", 32'(count), 32'd3);

        // handshake coinciding with start must not be taken
        in_valid = 1'b1; start = 1'b1;
        #1 checkOutput("start_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 begin start = 1'b0; in_valid = 1'b0; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("start_hs_no_we", 32'(mem_we), 32'd0);
        end

        applyStimulus(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_enc_no_we", 32'(mem_we), 32'd0);
        end
        checkOutput("abort_enc_count", 32'(count), 32'd0);
        checkOutput("abort_enc_ready", 32'(in_ready), 32'd1);
        applyStimulus(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFF_F800);
        expectWrite("addi_min", 32'd0, 32'h80000093);

        applyStimulus(CLS_ITYPE, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstwr_we", 32'(mem_we), 32'd0);
        checkOutput("rstwr_addr", 32'(mem_addr), 32'd0);
        checkOutput("rstwr_wdata", mem_wdata, 32'd0);
        checkOutput("rstwr_count", 32'(count), 32'd0);
        checkOutput("rstwr_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstwr_no_we", 32'(mem_we), 32'd0);
        end
        applyStimulus(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2047);
        expectWrite("addi_max", 32'd0, 32'h7FF00093);
        @(negedge clk);
        checkOutput("final_count", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
